// File: rtl/spi_cmd_pkg.sv
// ============================================================================
//  Module   : spi_cmd_pkg
//  Brief    : Shared opcodes, frame field positions and FSM encoding for the
//             SPI command decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_cmd_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;

    localparam int OPC_MSB  = 17;
    localparam int ADDR_MSB = 15;
    localparam int DATA_MSB = 7;

    localparam logic [7:0] STATUS_CNT_ADDR = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [7:0] addr, input int num_regs);
        return int'(addr) < num_regs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_regbank.sv
// ============================================================================
//  Module   : spi_cmd_regbank
//  Brief    : NUM_REGS x 8-bit control register array with one write port,
//             a combinational read port and address range check.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_regbank
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS      = 16,
    parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_wr_addr,
    input  logic [7:0]            i_wr_data,
    input  logic [7:0]            i_rd_addr,
    output logic [7:0]            o_rd_data,
    output logic                  o_rd_in_range,
    output logic [NUM_REGS*8-1:0] o_reg_flat
);

    logic [7:0] regs_q [NUM_REGS];

    // Address match per element also rejects out-of-range writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= REG_RESET_VAL;
        end else if (i_wr_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (i_wr_addr == 8'(k)) regs_q[k] <= i_wr_data;
            end
        end
    end

    always_comb begin
        o_rd_data = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_rd_addr == 8'(k)) o_rd_data = regs_q[k];
        end
    end

    assign o_rd_in_range = addr_in_range(i_rd_addr, NUM_REGS);

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign o_reg_flat[k*8 +: 8] = regs_q[k];
    end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
// ============================================================================
//  Module   : spi_cmd_decoder
//  Brief    : Decodes 18-bit SPI frames into register read/write/status ops
//             and returns a one-frame-pipelined response.
//             Optional error counter: define SPI_CMD_ERRCNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS      = 16,
    parameter logic [7:0] REG_RESET_VAL = 8'h00,
    parameter logic [7:0] OOR_READ_VAL  = 8'hEE
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_RX_DV,
    input  logic [17:0]           i_RX_Byte,
    output logic                  o_TX_DV,
    output logic [17:0]           o_TX_Byte,
    output logic [NUM_REGS*8-1:0] o_Reg_Flat,
    output logic                  o_Wr_Strobe,
    output logic [7:0]            o_Wr_Addr,
    output logic                  o_Overrun
);

    state_t      state_q;
    logic [17:0] frame_q, resp_q, tx_byte_q;
    logic        wr_pend_q, err_q, overrun_q, tx_dv_q, wr_strobe_q;
    logic [7:0]  wr_addr_q;

    logic [1:0]  w_opc;
    logic [7:0]  w_addr, w_data, w_rd_data, w_payload, w_status_payload;
    logic        w_in_range, w_decode, w_ovr_evt, w_oor_evt, w_cnt_sel, w_flag_clr, w_wr_en;

    assign w_opc  = frame_q[OPC_MSB -: 2];
    assign w_addr = frame_q[ADDR_MSB -: 8];
    assign w_data = frame_q[DATA_MSB -: 8];

    assign w_decode  = (state_q == ST_DECODE);
    assign w_ovr_evt = i_RX_DV && (state_q != ST_IDLE);
    assign w_oor_evt = w_decode && ((w_opc == OP_WRITE) || (w_opc == OP_READ)) && !w_in_range;
    assign w_wr_en   = (state_q == ST_RESP) && wr_pend_q;

`ifdef SPI_CMD_ERRCNT_EN
    logic [7:0] errcnt_q;
    logic [8:0] w_cnt_sum;

    assign w_cnt_sel = w_decode && (w_opc == OP_STATUS) && (w_addr == STATUS_CNT_ADDR);
    // Clear happens before this cycle's events are added, so they survive.
    assign w_cnt_sum = (w_cnt_sel ? 9'd0 : {1'b0, errcnt_q}) + 9'(w_oor_evt) + 9'(w_ovr_evt);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) errcnt_q <= 8'h00;
        else          errcnt_q <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
    end

    assign w_status_payload = w_cnt_sel ? errcnt_q : {overrun_q, err_q, 6'b0};
`else
    assign w_cnt_sel        = 1'b0;
    assign w_status_payload = {overrun_q, err_q, 6'b0};
`endif

    assign w_flag_clr = w_decode && (w_opc == OP_STATUS) && !w_cnt_sel;

    always_comb begin
        w_payload = 8'h00;
        case (w_opc)
            OP_WRITE:  w_payload = w_data;
            OP_READ:   w_payload = w_in_range ? w_rd_data : OOR_READ_VAL;
            OP_STATUS: w_payload = w_status_payload;
            default:   w_payload = 8'h00;
        endcase
    end

    spi_cmd_regbank #(
        .NUM_REGS      (NUM_REGS),
        .REG_RESET_VAL (REG_RESET_VAL)
    ) u_regbank (
        .i_clk         (i_Clk),
        .i_rst_n       (i_Rst_L),
        .i_wr_en       (w_wr_en),
        .i_wr_addr     (w_addr),
        .i_wr_data     (w_data),
        .i_rd_addr     (w_addr),
        .o_rd_data     (w_rd_data),
        .o_rd_in_range (w_in_range),
        .o_reg_flat    (o_Reg_Flat)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            frame_q     <= 18'h0;
            resp_q      <= 18'h0;
            tx_byte_q   <= 18'h0;
            wr_pend_q   <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
            tx_dv_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
        end else begin
            tx_dv_q     <= 1'b0;
            wr_strobe_q <= 1'b0;

            if (w_ovr_evt)       overrun_q <= 1'b1;
            else if (w_flag_clr) overrun_q <= 1'b0;

            if (w_oor_evt)       err_q <= 1'b1;
            else if (w_flag_clr) err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_RX_DV) begin
                        frame_q <= i_RX_Byte;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    resp_q    <= {w_opc, w_addr, w_payload};
                    wr_pend_q <= (w_opc == OP_WRITE) && w_in_range;
                    state_q   <= ST_RESP;
                end
                ST_RESP: begin
                    tx_dv_q   <= 1'b1;
                    tx_byte_q <= resp_q;
                    if (wr_pend_q) begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= w_addr;
                    end
                    wr_pend_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Wr_Strobe = wr_strobe_q;
    assign o_Wr_Addr   = wr_addr_q;
    assign o_Overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
// ============================================================================
//  Module   : tb_spi_cmd_decoder
//  Brief    : Self-checking bench for spi_cmd_decoder (NUM_REGS=16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_decoder;

    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_dv = 1'b0;
    logic [17:0]   rx_byte = 18'h0;
    logic          tx_dv;
    logic [17:0]   tx_byte;
    logic [NR*8-1:0] reg_flat;
    logic          wr_strobe;
    logic [7:0]    wr_addr;
    logic          overrun;

    spi_cmd_decoder #(
        .NUM_REGS      (NR),
        .REG_RESET_VAL (8'h00),
        .OOR_READ_VAL  (8'hEE)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .o_Reg_Flat  (reg_flat),
        .o_Wr_Strobe (wr_strobe),
        .o_Wr_Addr   (wr_addr),
        .o_Overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] frame;
        logic [17:0] resp;
        logic        stb;
    } vec_t;

    vec_t          vecs [12];
    logic [17:0]   sb [$];
    logic [7:0]    mreg [NR];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [17:0] fr(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    function automatic logic [NR*8-1:0] mflat();
        logic [NR*8-1:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) v[k*8 +: 8] = mreg[k];
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NR; k++) mreg[k] = 8'h00;
    endtask

    // Waits for the response of an already-driven frame; first sample is one edge after capture.
    task automatic collect(input logic [17:0] f, input logic exp_stb, input int exp_lat, input string tag);
        int cyc;
        logic [17:0] exp;
        cyc = 1;
        while (!tx_dv && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        exp = sb.pop_front();
        if (!tx_dv) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_tx_byte"}, 128'(tx_byte), 128'(exp));
            if (exp_lat > 0) check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
            check({tag, "_strobe"}, 128'(wr_strobe), 128'(exp_stb));
            if (exp_stb) begin
                check({tag, "_wr_addr"}, 128'(wr_addr), 128'(f[15:8]));
                mreg[int'(f[15:8])] = f[7:0];
            end
            check({tag, "_regs"}, 128'(reg_flat), 128'(mflat()));
        end
    endtask

    task automatic send(input logic [17:0] f, input logic [17:0] exp, input logic exp_stb, input string tag);
        sb.push_back(exp);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = f;
        @(negedge clk);
        rx_dv   = 1'b0;
        collect(f, exp_stb, 3, tag);
    endtask

    initial begin
        vecs[0]  = '{fr(2'd1, 8'h05, 8'h3C), fr(2'd1, 8'h05, 8'h3C), 1'b1};
        vecs[1]  = '{fr(2'd2, 8'h05, 8'h00), fr(2'd2, 8'h05, 8'h3C), 1'b0};
        vecs[2]  = '{fr(2'd2, 8'h20, 8'h00), fr(2'd2, 8'h20, 8'hEE), 1'b0};
        vecs[3]  = '{fr(2'd3, 8'h00, 8'h00), fr(2'd3, 8'h00, 8'h40), 1'b0};
        vecs[4]  = '{fr(2'd3, 8'h00, 8'h00), fr(2'd3, 8'h00, 8'h00), 1'b0};
        vecs[5]  = '{fr(2'd0, 8'h07, 8'h55), fr(2'd0, 8'h07, 8'h00), 1'b0};
        vecs[6]  = '{fr(2'd1, 8'h0F, 8'hA5), fr(2'd1, 8'h0F, 8'hA5), 1'b1};
        vecs[7]  = '{fr(2'd1, 8'h10, 8'h77), fr(2'd1, 8'h10, 8'h77), 1'b0};
        vecs[8]  = '{fr(2'd2, 8'h0F, 8'h00), fr(2'd2, 8'h0F, 8'hA5), 1'b0};
        vecs[9]  = '{fr(2'd3, 8'h00, 8'h00), fr(2'd3, 8'h00, 8'h40), 1'b0};
        vecs[10] = '{fr(2'd2, 8'h10, 8'h00), fr(2'd2, 8'h10, 8'hEE), 1'b0};
        vecs[11] = '{fr(2'd1, 8'hFF, 8'h12), fr(2'd1, 8'hFF, 8'h12), 1'b0};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_dv", 128'(tx_dv), 0);
        check("rst_tx_byte", 128'(tx_byte), 0);
        check("rst_strobe", 128'(wr_strobe), 0);
        check("rst_wr_addr", 128'(wr_addr), 0);
        check("rst_overrun", 128'(overrun), 0);
        check("rst_regs", 128'(reg_flat), 128'(mflat()));

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].frame, vecs[i].resp, vecs[i].stb, $sformatf("vec%0d", i));
        end

        // Clear the sticky error from the last vector.
        send(fr(2'd3, 8'h00, 8'h00), fr(2'd3, 8'h00, 8'h40), 1'b0, "stat_clr");

        // Back-to-back pulses: second frame lands in DECODE and is dropped.
        sb.push_back(fr(2'd1, 8'h02, 8'h11));
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = fr(2'd1, 8'h02, 8'h11);
        @(negedge clk);
        rx_byte = fr(2'd1, 8'h03, 8'h22);
        @(negedge clk);
        rx_dv   = 1'b0;
        collect(fr(2'd1, 8'h02, 8'h11), 1'b1, 0, "ovr");
        check("ovr_flag", 128'(overrun), 1);
        send(fr(2'd3, 8'h00, 8'h00), fr(2'd3, 8'h00, 8'h80), 1'b0, "ovr_stat");
        check("ovr_cleared", 128'(overrun), 0);

        // Reset asserted while a WRITE is in DECODE.
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = fr(2'd1, 8'h03, 8'hFF);
        @(negedge clk);
        rx_dv   = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_tx_dv", 128'(tx_dv), 0);
        check("mid_rst_tx_byte", 128'(tx_byte), 0);
        check("mid_rst_strobe", 128'(wr_strobe), 0);
        check("mid_rst_wr_addr", 128'(wr_addr), 0);
        check("mid_rst_overrun", 128'(overrun), 0);
        check("mid_rst_regs", 128'(reg_flat), 128'(mflat()));
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (tx_dv || wr_strobe) seen++;
            end
            check("mid_rst_no_resp", 128'(seen), 0);
        end
        check("mid_rst_regs_after", 128'(reg_flat), 128'(mflat()));
        send(fr(2'd3, 8'h00, 8'h00), fr(2'd3, 8'h00, 8'h00), 1'b0, "mid_rst_stat");

`ifdef SPI_CMD_ERRCNT_EN
        for (int i = 0; i < 3; i++) begin
            send(fr(2'd2, 8'h30, 8'h00), fr(2'd2, 8'h30, 8'hEE), 1'b0, $sformatf("cnt_rd%0d", i));
        end
        send(fr(2'd3, 8'h01, 8'h00), fr(2'd3, 8'h01, 8'h03), 1'b0, "cnt_stat");
        send(fr(2'd3, 8'h01, 8'h00), fr(2'd3, 8'h01, 8'h00), 1'b0, "cnt_stat2");
        send(fr(2'd3, 8'h00, 8'h00), fr(2'd3, 8'h00, 8'h40), 1'b0, "cnt_flags");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
